zic_nest_ctrl: RTL and testbench
================================

Name: zic_nest_ctrl

Overview:
Parametrised interrupt controller core that succeeds the fixed 48-line ZIC.
- Per-line enable and per-line edge/level mode; N sources, configurable level-priority width.
- Registered priority resolution.
- Request/ack handshake to the core.
- Hardware nesting stack of preempted active priorities, popped on end-of-interrupt.
- Sits between the ZIC MMR (config in, pending/status out) and the core interrupt interface.

Parameters:
NUM_INT, 48, number of interrupt sources (2..256)
LP_W, 8, level-priority width per source
ID_W, 8, interrupt id width (must satisfy 2^ID_W >= NUM_INT)
NEST_DEPTH, 4, max saved active priorities (1..16)

Ports:
zic_clk  in  1  clock
zic_rst  in  1  asynchronous reset, active-low
wdt_reset_i  in  1  synchronous clear, same effect as reset
int_src_i  in  NUM_INT  raw interrupt lines, synchronous to zic_clk
int_enable_i  in  NUM_INT  per-line enable from MMR
int_edge_mode_i  in  NUM_INT  1 = rising-edge, 0 = level
int_lp_i  in  NUM_INT*LP_W  flat level-priority; line k at [k*LP_W +: LP_W]
zic_ack_i  in  1  core acknowledges request
zic_ack_id_i  in  ID_W  id being acknowledged
zic_eoi_valid_i  in  1  end of current interrupt
interrupt_request_o  out  1  request to core
interrupt_id_o  out  ID_W  id of requested interrupt
interrupt_lp_o  out  LP_W  priority of requested interrupt
interrupt_pending_o  out  NUM_INT  pending bits to MMR
active_lp_o  out  LP_W  current active priority (0 = thread level)
nest_level_o  out  $clog2(NEST_DEPTH+1)  stack occupancy
ack_err_o  out  1  one-cycle pulse on invalid ack
eoi_err_o  out  1  one-cycle pulse on EOI with nothing active

Behaviour:
- Reset / wdt_reset_i:
  - All outputs 0; pending, stack and active_lp cleared.
  - Source sample register cleared, so a line that is high at reset release counts as an edge.
- Capture:
  - src_q <= int_src_i every cycle.
  - Edge line: set pending when int_src_i & ~src_q.
  - Level line: set pending while int_src_i is high.
  - Set only if enabled; disabling a line clears its pending bit next cycle.
- Clear: pending[id] clears on an accepted ack. A set in the same cycle wins, so the bit stays 1.
- Resolve (combinational over pending & enable, then registered):
  - Picks max lp; ties go to the lowest id.
  - Lines with lp == 0 never win.
  - Result feeds interrupt_id_o, interrupt_lp_o and internal best_valid.
  - Latency: pending change to updated outputs = 1 cycle.
- Request: interrupt_request_o = best_valid & (interrupt_lp_o > active_lp_o) & (nest_level_o < NEST_DEPTH). Equal priority never preempts.
- Accepted ack: zic_ack_i & interrupt_request_o & (zic_ack_id_i == interrupt_id_o).
  - Push active_lp_o; active_lp_o <= interrupt_lp_o; nest_level++; clear pending.
  - interrupt_request_o drops the next cycle. It re-asserts only after resolve updates and the new line is strictly higher than the new active priority.
- Any other zic_ack_i: ignored, ack_err_o pulses.
- EOI with nest_level > 0: active_lp_o <= stack top; nest_level--.
- EOI with nest_level == 0: ignored, eoi_err_o pulses.
- Ack accepted and EOI in the same cycle: the acked interrupt replaces the completing one.
  - active_lp_o <= interrupt_lp_o.
  - Stack and nest_level unchanged.
- Stack full (nest_level == NEST_DEPTH): request is held low and pending is retained. No overflow is possible.
- State per nest level: IDLE (level 0) -> ACTIVE(n). Ack goes n -> n+1; EOI goes n -> n-1; ack+EOI stays at n.

Test Plan:
1. Edge on line 5, lp 3, enabled, active 0 -> pending[5] next cycle; request, id 5, lp 3 one cycle later. Ack id 5 -> pending[5] = 0, active_lp = 3, nest 1, request low.
2. Lines 7 and 2 both lp 6 pending -> id 2 wins. Line 9 lp 9 then arrives during active 6 -> preempting request id 9. Ack -> nest 2, active 9. EOI -> active 6. EOI -> active 0, nest 0.
3. NEST_DEPTH = 2: ack lp 2, then lp 4. Line lp 7 then goes pending -> request stays low while nest 2. EOI -> request id of the lp 7 line.
4. Level line 3 held high and acked -> pending re-sets the next cycle. Same for an edge line, whose new edge coincides with the ack -> pending stays 1.
5. Ack with wrong id, ack while request low, EOI at nest 0 -> ack_err_o / eoi_err_o single-cycle pulses; no state change.
6. Active at nest 3 with pending lines:
   - wdt_reset_i pulse -> all cleared next edge.
   - zic_rst low mid-operation -> outputs 0 immediately (async).
   - Line high at reset release -> captured as an edge.

Source files
------------

// File: rtl/zic_nest_ctrl_if.sv
// zic_nest_ctrl_if: request/ack/EOI handshake between the interrupt controller and the core
interface zic_nest_ctrl_if #(
  parameter int ID_W = 8,
  parameter int LP_W = 8
);
  logic            interrupt_request_o;
  logic [ID_W-1:0] interrupt_id_o;
  logic [LP_W-1:0] interrupt_lp_o;
  logic            zic_ack_i;
  logic [ID_W-1:0] zic_ack_id_i;
  logic            zic_eoi_valid_i;
  modport master (
    output interrupt_request_o, interrupt_id_o, interrupt_lp_o,
    input  zic_ack_i, zic_ack_id_i, zic_eoi_valid_i
  );
  modport slave (
    input  interrupt_request_o, interrupt_id_o, interrupt_lp_o,
    output zic_ack_i, zic_ack_id_i, zic_eoi_valid_i
  );
endinterface

// File: rtl/zic_nest_ctrl.sv
// zic_nest_ctrl: prioritised interrupt controller with a nesting stack of preempted priorities
module zic_nest_ctrl #(
  parameter int NUM_INT    = 48,
  parameter int LP_W       = 8,
  parameter int ID_W       = 8,
  parameter int NEST_DEPTH = 4
) (
  input  logic                              zic_clk,
  input  logic                              zic_rst,
  input  logic                              wdt_reset_i,
  input  logic [NUM_INT-1:0]                int_src_i,
  input  logic [NUM_INT-1:0]                int_enable_i,
  input  logic [NUM_INT-1:0]                int_edge_mode_i,
  input  logic [NUM_INT*LP_W-1:0]           int_lp_i,
  zic_nest_ctrl_if.master                   core,
  output logic [NUM_INT-1:0]                interrupt_pending_o,
  output logic [LP_W-1:0]                   active_lp_o,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level_o,
  output logic                              ack_err_o,
  output logic                              eoi_err_o
);
  localparam int NL_W = $clog2(NEST_DEPTH + 1);
  localparam int SI_W = NEST_DEPTH > 1 ? $clog2(NEST_DEPTH) : 1;
  typedef struct packed {
    logic [NUM_INT-1:0]                src_q;
    logic [NUM_INT-1:0]                pending;
    logic [ID_W-1:0]                   id;
    logic [LP_W-1:0]                   lp;
    logic                              valid;
    logic [LP_W-1:0]                   active;
    logic [NEST_DEPTH-1:0][LP_W-1:0]   stack;
    logic [NL_W-1:0]                   nest;
    logic                              ack_err;
    logic                              eoi_err;
  } state_t;
  state_t q, d;
  logic [ID_W-1:0]    res_id;
  logic [LP_W-1:0]    res_lp;
  logic               req, accept, eoi_ok;
  logic [NUM_INT-1:0] pend_set, pend_clr;
  logic [SI_W-1:0]    push_idx, pop_idx;
  assign req = q.valid & (q.lp > q.active) & (q.nest < NL_W'(NEST_DEPTH));
  assign core.interrupt_request_o = req;
  assign core.interrupt_id_o = q.id;
  assign core.interrupt_lp_o = q.lp;
  assign interrupt_pending_o = q.pending;
  assign active_lp_o = q.active;
  assign nest_level_o = q.nest;
  assign ack_err_o = q.ack_err;
  assign eoi_err_o = q.eoi_err;
  assign accept = core.zic_ack_i & req & (core.zic_ack_id_i == q.id);
  assign eoi_ok = core.zic_eoi_valid_i & (q.nest != '0);
  // an edge line needs a low sample last cycle, a level line only needs to be high
  assign pend_set = int_enable_i & int_src_i & ~(int_edge_mode_i & q.src_q);
  assign pend_clr = accept ? NUM_INT'(1) << q.id : '0;
  assign push_idx = SI_W'(q.nest);
  assign pop_idx = SI_W'(q.nest - 1'b1);
  // strict compare keeps the lowest id on ties and never lets lp 0 win
  always_comb begin
    res_id = '0;
    res_lp = '0;
    for (int k = 0; k < NUM_INT; k++)
      if (q.pending[k] && int_enable_i[k] && int_lp_i[k*LP_W +: LP_W] > res_lp) begin
        res_id = ID_W'(k);
        res_lp = int_lp_i[k*LP_W +: LP_W];
      end
  end
  always_comb begin
    d = q;
    d.src_q = int_src_i;
    d.pending = (q.pending & ~pend_clr | pend_set) & int_enable_i;
    d.id = res_id;
    d.lp = res_lp;
    d.valid = res_lp != '0;
    d.ack_err = core.zic_ack_i & ~accept;
    d.eoi_err = core.zic_eoi_valid_i & ~eoi_ok;
    d.active = accept ? q.lp : eoi_ok ? q.stack[pop_idx] : q.active;
    d.nest = accept && !eoi_ok ? q.nest + 1'b1 : eoi_ok && !accept ? q.nest - 1'b1 : q.nest;
    if (accept && !eoi_ok) d.stack[push_idx] = q.active;
    if (wdt_reset_i) d = '0;
  end
  always_ff @(posedge zic_clk or negedge zic_rst)
    if (!zic_rst) q <= '0;
    else q <= d;
endmodule

// File: tb/tb_zic_nest_ctrl.sv
// tb_zic_nest_ctrl: directed and randomised checks of zic_nest_ctrl against a queue-based model
module tb_zic_nest_ctrl;
  localparam int N = 12, LP_W = 4, ID_W = 4, D = 3, NL_W = 2;
  logic zic_clk = 0, zic_rst = 0, wdt_reset_i = 0;
  logic [N-1:0] src = '0, en = '0, edge_m = '0;
  logic [LP_W-1:0] lpv [N];
  logic [N*LP_W-1:0] lp_flat;
  logic [N-1:0] pend;
  logic [LP_W-1:0] active;
  logic [NL_W-1:0] nest;
  logic ack_err, eoi_err;
  int checks = 0, errors = 0;
  bit m_src [N];
  bit m_pend [N];
  int m_id, m_lp, m_active;
  bit m_valid, m_ack_err, m_eoi_err;
  int stk [$];

  zic_nest_ctrl_if #(.ID_W(ID_W), .LP_W(LP_W)) bus ();
  zic_nest_ctrl #(.NUM_INT(N), .LP_W(LP_W), .ID_W(ID_W), .NEST_DEPTH(D)) dut (
    .zic_clk(zic_clk), .zic_rst(zic_rst), .wdt_reset_i(wdt_reset_i),
    .int_src_i(src), .int_enable_i(en), .int_edge_mode_i(edge_m), .int_lp_i(lp_flat),
    .core(bus), .interrupt_pending_o(pend), .active_lp_o(active), .nest_level_o(nest),
    .ack_err_o(ack_err), .eoi_err_o(eoi_err));

  always #5 zic_clk = ~zic_clk;
  always_comb for (int k = 0; k < N; k++) lp_flat[k*LP_W +: LP_W] = lpv[k];

  function automatic void m_reset();
    foreach (m_src[k]) begin m_src[k] = 0; m_pend[k] = 0; end
    m_id = 0; m_lp = 0; m_valid = 0; m_active = 0; m_ack_err = 0; m_eoi_err = 0;
    stk.delete();
  endfunction

  function automatic bit m_req();
    return m_valid && m_lp > m_active && stk.size() < D;
  endfunction

  function automatic void m_edge();
    bit acc, eoi_ok, rise, set;
    int mx, id;
    if (!zic_rst || wdt_reset_i) begin m_reset(); return; end
    acc = bus.zic_ack_i && m_req() && int'(bus.zic_ack_id_i) == m_id;
    eoi_ok = bus.zic_eoi_valid_i && stk.size() > 0;
    mx = 0; id = 0;
    foreach (m_pend[k]) if (m_pend[k] && en[k] && int'(lpv[k]) > mx) mx = int'(lpv[k]);
    for (int k = N - 1; k >= 0; k--) if (mx > 0 && m_pend[k] && en[k] && int'(lpv[k]) == mx) id = k;
    m_ack_err = bus.zic_ack_i && !acc;
    m_eoi_err = bus.zic_eoi_valid_i && !eoi_ok;
    if (acc && eoi_ok) m_active = m_lp;
    else if (acc) begin stk.push_back(m_active); m_active = m_lp; end
    else if (eoi_ok) m_active = stk.pop_back();
    for (int k = 0; k < N; k++) begin
      rise = src[k] && !m_src[k];
      set = edge_m[k] ? rise : src[k];
      m_pend[k] = en[k] && (set || (m_pend[k] && !(acc && k == m_id)));
      m_src[k] = src[k];
    end
    m_id = id; m_lp = mx; m_valid = mx > 0;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] p;
    foreach (m_pend[k]) p[k] = m_pend[k];
    chk("request", 32'(bus.interrupt_request_o), 32'(m_req()));
    chk("id", 32'(bus.interrupt_id_o), m_id);
    chk("lp", 32'(bus.interrupt_lp_o), m_lp);
    chk("pending", 32'(pend), 32'(p));
    chk("active_lp", 32'(active), m_active);
    chk("nest_level", 32'(nest), stk.size());
    chk("ack_err", 32'(ack_err), 32'(m_ack_err));
    chk("eoi_err", 32'(eoi_err), 32'(m_eoi_err));
  endtask

  task automatic step();
    m_edge();
    @(posedge zic_clk);
    #1;
    check_all();
  endtask

  task automatic raise(int k);
    src[k] = 1; step(); src[k] = 0; step();
  endtask

  task automatic ack(int id);
    bus.zic_ack_i = 1; bus.zic_ack_id_i = ID_W'(id); step(); bus.zic_ack_i = 0;
  endtask

  task automatic eoi();
    bus.zic_eoi_valid_i = 1; step(); bus.zic_eoi_valid_i = 0;
  endtask

  task automatic cleanup();
    en = '0; src = '0; edge_m = '0;
    foreach (lpv[k]) lpv[k] = '0;
    while (stk.size() > 0) eoi();
    repeat (2) step();
    en = '1;
  endtask

  task automatic build_nest3();
    lpv[1] = 2; lpv[4] = 4; lpv[6] = 5; lpv[8] = 7;
    raise(1); ack(1); raise(4); ack(4); raise(6); ack(6);
    src[8] = 1; step(); src[8] = 0; repeat (2) step();
  endtask

  initial begin
    foreach (lpv[k]) lpv[k] = '0;
    bus.zic_ack_i = 0; bus.zic_ack_id_i = '0; bus.zic_eoi_valid_i = 0;
    m_reset();
    repeat (2) step();
    #2 zic_rst = 1;
    en = '1;
    step();
    // edge line, request one cycle after pending, ack pushes thread level
    lpv[5] = 3; edge_m[5] = 1; src[5] = 1; step(); src[5] = 0;
    chk("t1_pend5", 32'(pend[5]), 1);
    step();
    chk("t1_req", 32'(bus.interrupt_request_o), 1);
    chk("t1_id", 32'(bus.interrupt_id_o), 5);
    chk("t1_lp", 32'(bus.interrupt_lp_o), 3);
    ack(5);
    chk("t1_ack_pend5", 32'(pend[5]), 0);
    chk("t1_active", 32'(active), 3);
    chk("t1_nest", 32'(nest), 1);
    chk("t1_req_drop", 32'(bus.interrupt_request_o), 0);
    cleanup();
    // tie break, equal priority no preempt, preemption and unwinding
    lpv[2] = 6; lpv[7] = 6; lpv[9] = 9; src[2] = 1; src[7] = 1; step(); src = '0; step();
    chk("t2_tie_id", 32'(bus.interrupt_id_o), 2);
    ack(2); step();
    chk("t2_equal_no_preempt", 32'(bus.interrupt_request_o), 0);
    raise(9);
    chk("t2_preempt_req", 32'(bus.interrupt_request_o), 1);
    chk("t2_preempt_id", 32'(bus.interrupt_id_o), 9);
    ack(9);
    chk("t2_nest2", 32'(nest), 2);
    chk("t2_active9", 32'(active), 9);
    eoi();
    chk("t2_pop_active6", 32'(active), 6);
    eoi();
    chk("t2_pop_active0", 32'(active), 0);
    chk("t2_nest0", 32'(nest), 0);
    cleanup();
    // full stack holds request low until an EOI frees a slot
    build_nest3();
    chk("t3_full_req", 32'(bus.interrupt_request_o), 0);
    chk("t3_pend8", 32'(pend[8]), 1);
    chk("t3_nest3", 32'(nest), 3);
    eoi();
    chk("t3_req", 32'(bus.interrupt_request_o), 1);
    chk("t3_id", 32'(bus.interrupt_id_o), 8);
    chk("t3_active4", 32'(active), 4);
    cleanup();
    // set wins over ack clear, level and edge
    lpv[3] = 5; src[3] = 1; repeat (2) step();
    chk("t4_lvl_req", 32'(bus.interrupt_request_o), 1);
    chk("t4_lvl_id", 32'(bus.interrupt_id_o), 3);
    ack(3);
    chk("t4_lvl_repend", 32'(pend[3]), 1);
    chk("t4_lvl_active", 32'(active), 5);
    src[3] = 0; cleanup();
    lpv[10] = 6; edge_m[10] = 1; src[10] = 1; step(); src[10] = 0; step();
    chk("t4_edge_req", 32'(bus.interrupt_request_o), 1);
    chk("t4_edge_id", 32'(bus.interrupt_id_o), 10);
    src[10] = 1; ack(10);
    chk("t4_edge_repend", 32'(pend[10]), 1);
    src[10] = 0; cleanup();
    // error pulses
    ack(0);
    chk("t5_ack_err_low_req", 32'(ack_err), 1);
    step();
    chk("t5_ack_err_pulse", 32'(ack_err), 0);
    eoi();
    chk("t5_eoi_err", 32'(eoi_err), 1);
    chk("t5_eoi_nest", 32'(nest), 0);
    step();
    chk("t5_eoi_err_pulse", 32'(eoi_err), 0);
    lpv[5] = 3; raise(5); ack(4);
    chk("t5_wrong_id_err", 32'(ack_err), 1);
    chk("t5_wrong_id_nest", 32'(nest), 0);
    chk("t5_wrong_id_pend", 32'(pend[5]), 1);
    chk("t5_wrong_id_req", 32'(bus.interrupt_request_o), 1);
    cleanup();
    // watchdog clear, async reset, line high at release
    build_nest3();
    wdt_reset_i = 1; step(); wdt_reset_i = 0;
    chk("t6_wdt_nest", 32'(nest), 0);
    chk("t6_wdt_pend", 32'(pend), 0);
    chk("t6_wdt_active", 32'(active), 0);
    build_nest3();
    zic_rst = 0;
    #1;
    m_reset();
    check_all();
    chk("t6_async_nest", 32'(nest), 0);
    chk("t6_async_active", 32'(active), 0);
    lpv[5] = 3; edge_m[5] = 1; src[5] = 1; step();
    #2 zic_rst = 1;
    step();
    chk("t6_edge_at_release", 32'(pend[5]), 1);
    step();
    chk("t6_release_req", 32'(bus.interrupt_request_o), 1);
    chk("t6_release_id", 32'(bus.interrupt_id_o), 5);
    cleanup();
    // randomised traffic against the model
    foreach (lpv[k]) lpv[k] = LP_W'($urandom);
    for (int i = 0; i < 800; i++) begin
      src = N'($urandom);
      en = N'($urandom | $urandom | $urandom);
      if ($urandom_range(7) == 0) edge_m = N'($urandom);
      if ($urandom_range(15) == 0) foreach (lpv[k]) lpv[k] = LP_W'($urandom);
      bus.zic_ack_i = $urandom_range(2) == 0;
      bus.zic_ack_id_i = $urandom_range(3) == 0 ? ID_W'($urandom) : ID_W'(m_id);
      bus.zic_eoi_valid_i = $urandom_range(3) == 0;
      wdt_reset_i = $urandom_range(150) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
